// File: rtl/lsb_queue_if.sv
// Bus bundle between the load/store buffer and its neighbours: issue, both CDBs,
// ROB commit/rollback, the memory controller and the load-result broadcast.
interface lsb_queue_if #(
  parameter int TAG_W = 4,
  parameter int XLEN  = 32
);
  logic             issue_valid;
  logic             issue_is_store;
  logic [2:0]       issue_funct3;
  logic [TAG_W-1:0] issue_tag;
  logic [XLEN-1:0]  issue_vj;
  logic             issue_qj_busy;
  logic [TAG_W-1:0] issue_qj;
  logic [XLEN-1:0]  issue_vk;
  logic             issue_qk_busy;
  logic [TAG_W-1:0] issue_qk;
  logic [XLEN-1:0]  issue_imm;
  logic             full_out;

  logic             cdb0_valid;
  logic [TAG_W-1:0] cdb0_tag;
  logic [XLEN-1:0]  cdb0_value;
  logic             cdb1_valid;
  logic [TAG_W-1:0] cdb1_tag;
  logic [XLEN-1:0]  cdb1_value;

  logic             commit_valid;
  logic [TAG_W-1:0] commit_tag;
  logic             roll_back;

  // Memory side: mem_req_valid is a one-cycle request pulse (no ready);
  // mem_done is a one-cycle completion pulse answering the outstanding request.
  logic             mem_req_valid;
  logic             mem_req_we;
  logic [XLEN-1:0]  mem_req_addr;
  logic [XLEN-1:0]  mem_req_wdata;
  logic [1:0]       mem_req_size;
  logic             mem_done;
  logic [XLEN-1:0]  mem_rdata;

  logic             ld_bcast_valid;
  logic [TAG_W-1:0] ld_bcast_tag;
  logic [XLEN-1:0]  ld_bcast_value;

  modport slave (
    input  issue_valid, issue_is_store, issue_funct3, issue_tag, issue_vj, issue_qj_busy,
           issue_qj, issue_vk, issue_qk_busy, issue_qk, issue_imm,
           cdb0_valid, cdb0_tag, cdb0_value, cdb1_valid, cdb1_tag, cdb1_value,
           commit_valid, commit_tag, roll_back, mem_done, mem_rdata,
    output full_out, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_size,
           ld_bcast_valid, ld_bcast_tag, ld_bcast_value
  );

  modport master (
    output issue_valid, issue_is_store, issue_funct3, issue_tag, issue_vj, issue_qj_busy,
           issue_qj, issue_vk, issue_qk_busy, issue_qk, issue_imm,
           cdb0_valid, cdb0_tag, cdb0_value, cdb1_valid, cdb1_tag, cdb1_value,
           commit_valid, commit_tag, roll_back, mem_done, mem_rdata,
    input  full_out, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_size,
           ld_bcast_valid, ld_bcast_tag, ld_bcast_value
  );
endinterface

// File: rtl/lsb_queue.sv
// In-order circular load/store buffer: CDB operand wakeup, head-only execution,
// stores gated by ROB commit, rollback keeping committed stores.
module lsb_queue #(
  parameter int LSB_DEPTH = 16,
  parameter int PTR_W     = 4,
  parameter int TAG_W     = 4,
  parameter int XLEN      = 32
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  lsb_queue_if.slave     bus,
  output logic           dbg_fsm_state,
  output logic [PTR_W:0] dbg_count
);
  localparam logic [1:0] E_EMPTY  = 2'd0;
  localparam logic [1:0] E_WAIT   = 2'd1;
  localparam logic [1:0] E_READY  = 2'd2;
  localparam logic [1:0] E_COMMIT = 2'd3;
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_MEM    = 1'b1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(LSB_DEPTH);

  logic [1:0]       e_state   [LSB_DEPTH];
  logic             e_store   [LSB_DEPTH];
  logic [2:0]       e_funct3  [LSB_DEPTH];
  logic [TAG_W-1:0] e_tag     [LSB_DEPTH];
  logic [XLEN-1:0]  e_vj      [LSB_DEPTH];
  logic             e_qj_busy [LSB_DEPTH];
  logic [TAG_W-1:0] e_qj      [LSB_DEPTH];
  logic [XLEN-1:0]  e_vk      [LSB_DEPTH];
  logic             e_qk_busy [LSB_DEPTH];
  logic [TAG_W-1:0] e_qk      [LSB_DEPTH];
  logic [XLEN-1:0]  e_imm     [LSB_DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;
  logic [0:0]       fsm;
  logic             orphan;  // outstanding load was flushed; its slot is already released

  // Operand snoop: returns {busy, value}; cdb0 has priority over cdb1.
  function automatic logic [XLEN:0] snoop(
    input logic busy, input logic [TAG_W-1:0] q, input logic [XLEN-1:0] v,
    input logic c0v, input logic [TAG_W-1:0] c0t, input logic [XLEN-1:0] c0d,
    input logic c1v, input logic [TAG_W-1:0] c1t, input logic [XLEN-1:0] c1d);
    if (busy && c0v && c0t == q) return {1'b0, c0d};
    if (busy && c1v && c1t == q) return {1'b0, c1d};
    return {busy, v};
  endfunction

  function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [XLEN-1:0] d);
    case (f3[1:0])
      2'b00:   return {{(XLEN-8){~f3[2] & d[7]}}, d[7:0]};
      2'b01:   return {{(XLEN-16){~f3[2] & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  logic [XLEN:0] w_j [LSB_DEPTH];
  logic [XLEN:0] w_k [LSB_DEPTH];
  logic [XLEN:0] iss_j, iss_k;
  logic [PTR_W:0] n_commit;

  always_comb begin
    n_commit = '0;
    for (int i = 0; i < LSB_DEPTH; i++) begin
      w_j[i] = snoop(e_qj_busy[i], e_qj[i], e_vj[i], bus.cdb0_valid, bus.cdb0_tag, bus.cdb0_value,
                     bus.cdb1_valid, bus.cdb1_tag, bus.cdb1_value);
      w_k[i] = snoop(e_qk_busy[i], e_qk[i], e_vk[i], bus.cdb0_valid, bus.cdb0_tag, bus.cdb0_value,
                     bus.cdb1_valid, bus.cdb1_tag, bus.cdb1_value);
      n_commit = n_commit + {{PTR_W{1'b0}}, (e_state[i] == E_COMMIT)};
    end
    iss_j = snoop(bus.issue_qj_busy, bus.issue_qj, bus.issue_vj, bus.cdb0_valid, bus.cdb0_tag,
                  bus.cdb0_value, bus.cdb1_valid, bus.cdb1_tag, bus.cdb1_value);
    iss_k = snoop(bus.issue_is_store & bus.issue_qk_busy, bus.issue_qk, bus.issue_vk,
                  bus.cdb0_valid, bus.cdb0_tag, bus.cdb0_value,
                  bus.cdb1_valid, bus.cdb1_tag, bus.cdb1_value);
  end

  logic             do_issue, start, deq, head_load_mem, store_done, rb_adv;
  logic [PTR_W-1:0] rb_head, rb_tail;
  logic [PTR_W:0]   rb_count, nxt_count;

  assign bus.full_out = (count == DEPTH_C);
  assign do_issue   = bus.issue_valid && !bus.full_out && !bus.roll_back;
  assign start      = (fsm == S_IDLE) && !bus.roll_back &&
                      ((e_state[head] == E_READY && !e_store[head]) ||
                       (e_state[head] == E_COMMIT && e_store[head]));
  assign deq        = (fsm == S_MEM) && bus.mem_done && !orphan;
  assign head_load_mem = (fsm == S_MEM) && !orphan && !e_store[head];
  assign store_done = deq && e_store[head];
  assign rb_adv     = head_load_mem || store_done;
  assign rb_head    = head + {{(PTR_W-1){1'b0}}, rb_adv};
  assign rb_count   = n_commit - {{PTR_W{1'b0}}, store_done};
  assign rb_tail    = rb_head + rb_count[PTR_W-1:0];
  assign nxt_count  = count + {{PTR_W{1'b0}}, do_issue} - {{PTR_W{1'b0}}, deq};

  assign dbg_fsm_state = fsm[0];
  assign dbg_count     = count;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < LSB_DEPTH; i++) begin
        e_state[i] <= E_EMPTY;  e_store[i] <= 1'b0;   e_funct3[i] <= '0; e_tag[i] <= '0;
        e_vj[i] <= '0;          e_qj_busy[i] <= 1'b0; e_qj[i] <= '0;
        e_vk[i] <= '0;          e_qk_busy[i] <= 1'b0; e_qk[i] <= '0;     e_imm[i] <= '0;
      end
      head <= '0; tail <= '0; count <= '0; fsm <= S_IDLE; orphan <= 1'b0;
      bus.mem_req_valid <= 1'b0; bus.mem_req_we <= 1'b0; bus.mem_req_addr <= '0;
      bus.mem_req_wdata <= '0;   bus.mem_req_size <= '0;
      bus.ld_bcast_valid <= 1'b0; bus.ld_bcast_tag <= '0; bus.ld_bcast_value <= '0;
    end else if (rdy_in) begin
      bus.mem_req_valid  <= 1'b0;
      bus.ld_bcast_valid <= 1'b0;

      for (int i = 0; i < LSB_DEPTH; i++) begin
        if (bus.roll_back) begin
          if (e_state[i] != E_COMMIT) e_state[i] <= E_EMPTY;
        end else begin
          if (e_state[i] == E_WAIT) begin
            e_qj_busy[i] <= w_j[i][XLEN]; e_vj[i] <= w_j[i][XLEN-1:0];
            e_qk_busy[i] <= w_k[i][XLEN]; e_vk[i] <= w_k[i][XLEN-1:0];
            if (!w_j[i][XLEN] && !w_k[i][XLEN]) e_state[i] <= E_READY;
          end
          if (bus.commit_valid && e_state[i] == E_READY && e_store[i] && e_tag[i] == bus.commit_tag)
            e_state[i] <= E_COMMIT;
        end
      end

      if (do_issue) begin
        e_state[tail]   <= (iss_j[XLEN] || iss_k[XLEN]) ? E_WAIT : E_READY;
        e_store[tail]   <= bus.issue_is_store;
        e_funct3[tail]  <= bus.issue_funct3;
        e_tag[tail]     <= bus.issue_tag;
        e_vj[tail]      <= iss_j[XLEN-1:0];
        e_qj_busy[tail] <= iss_j[XLEN];
        e_qj[tail]      <= bus.issue_qj;
        e_vk[tail]      <= iss_k[XLEN-1:0];
        e_qk_busy[tail] <= iss_k[XLEN];
        e_qk[tail]      <= bus.issue_qk;
        e_imm[tail]     <= bus.issue_imm;
      end

      if (deq) e_state[head] <= E_EMPTY;

      if (bus.roll_back) begin
        head <= rb_head; tail <= rb_tail; count <= rb_count;
      end else begin
        if (deq) head <= head + 1'b1;
        if (do_issue) tail <= tail + 1'b1;
        count <= nxt_count;
      end

      if (fsm == S_IDLE) begin
        if (start) begin
          fsm               <= S_MEM;
          bus.mem_req_valid <= 1'b1;
          bus.mem_req_we    <= e_store[head];
          bus.mem_req_addr  <= e_vj[head] + e_imm[head];
          bus.mem_req_wdata <= e_vk[head];
          bus.mem_req_size  <= e_funct3[head][1:0];
        end
      end else if (bus.mem_done) begin
        fsm    <= S_IDLE;
        orphan <= 1'b0;
        if (deq && !e_store[head] && !bus.roll_back) begin
          bus.ld_bcast_valid <= 1'b1;
          bus.ld_bcast_tag   <= e_tag[head];
          bus.ld_bcast_value <= load_ext(e_funct3[head], bus.mem_rdata);
        end
      end else if (bus.roll_back && head_load_mem) begin
        orphan <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lsb_queue.sv
// Scoreboarded bench for lsb_queue: expected memory requests and load broadcasts are
// queued at issue time and popped by a negedge monitor; a small responder models memory.
module tb_lsb_queue;
  localparam int TAG_W = 4;
  localparam int XLEN  = 32;
  localparam int DEPTH = 16;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       rdy_in;
  logic       dbg_fsm_state;
  logic [4:0] dbg_count;

  lsb_queue_if #(.TAG_W(TAG_W), .XLEN(XLEN)) bus ();

  lsb_queue #(.LSB_DEPTH(DEPTH), .PTR_W(4), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus),
    .dbg_fsm_state(dbg_fsm_state), .dbg_count(dbg_count)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;
  int req_seen = 0;
  logic [66:0] exp_req_q[$];
  logic [66:0] exp_bc_q[$];
  logic [31:0] rd_q[$];
  int   mem_lat = 1;
  logic mem_hold = 1'b0;

  task automatic chk(input string name, input logic [66:0] obs, input logic [66:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [66:0] req_word(input logic we, input logic [1:0] size,
                                           input logic [31:0] addr, input logic [31:0] wdata);
    return {we, size, addr, wdata};
  endfunction

  function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [31:0] rd);
    case (f3)
      3'b000:  return {{24{rd[7]}}, rd[7:0]};
      3'b001:  return {{16{rd[15]}}, rd[15:0]};
      3'b100:  return {24'h0, rd[7:0]};
      3'b101:  return {16'h0, rd[15:0]};
      default: return rd;
    endcase
  endfunction

  task automatic expect_load(input logic [3:0] tag, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] rd);
    exp_req_q.push_back(req_word(1'b0, f3[1:0], addr, 32'h0));
    rd_q.push_back(rd);
    exp_bc_q.push_back({31'h0, tag, model_ext(f3, rd)});
  endtask

  // Scoreboard monitor
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (bus.mem_req_valid) begin
        req_seen++;
        if (exp_req_q.size() == 0) chk("req_extra", 67'd1, 67'd0);
        else chk("mem_req", req_word(bus.mem_req_we, bus.mem_req_size, bus.mem_req_addr,
                                     bus.mem_req_wdata), exp_req_q.pop_front());
      end
      if (bus.ld_bcast_valid) begin
        if (exp_bc_q.size() == 0) chk("bcast_extra", 67'd1, 67'd0);
        else chk("ld_bcast", {31'h0, bus.ld_bcast_tag, bus.ld_bcast_value}, exp_bc_q.pop_front());
      end
    end
  end

  // Memory responder
  initial begin
    bit is_ld;
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk_in);
      if (bus.mem_req_valid) begin
        is_ld = !bus.mem_req_we;
        for (int g = 0; g < 2000 && mem_hold; g++) @(negedge clk_in);
        repeat (mem_lat) @(negedge clk_in);
        bus.mem_rdata = (is_ld && rd_q.size() != 0) ? rd_q.pop_front() : $urandom;
        bus.mem_done  = 1'b1;
        @(negedge clk_in);
        bus.mem_done  = 1'b0;
      end
    end
  end

  task automatic issue_op(input logic st, input logic [2:0] f3, input logic [3:0] tag,
                          input logic [31:0] vj, input logic qjb, input logic [3:0] qj,
                          input logic [31:0] vk, input logic qkb, input logic [3:0] qk,
                          input logic [31:0] imm);
    bus.issue_valid = 1'b1; bus.issue_is_store = st; bus.issue_funct3 = f3; bus.issue_tag = tag;
    bus.issue_vj = vj; bus.issue_qj_busy = qjb; bus.issue_qj = qj;
    bus.issue_vk = vk; bus.issue_qk_busy = qkb; bus.issue_qk = qk; bus.issue_imm = imm;
    @(negedge clk_in);
    bus.issue_valid = 1'b0;
  endtask

  task automatic cdb_pulse(input int which, input logic [3:0] tag, input logic [31:0] val);
    if (which == 0) begin bus.cdb0_valid = 1'b1; bus.cdb0_tag = tag; bus.cdb0_value = val; end
    else begin bus.cdb1_valid = 1'b1; bus.cdb1_tag = tag; bus.cdb1_value = val; end
    @(negedge clk_in);
    bus.cdb0_valid = 1'b0; bus.cdb1_valid = 1'b0;
  endtask

  task automatic commit_pulse(input logic [3:0] tag);
    bus.commit_valid = 1'b1; bus.commit_tag = tag;
    @(negedge clk_in);
    bus.commit_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_req_q.size() == 0 && exp_bc_q.size() == 0 && dbg_count == 0 && dbg_fsm_state == 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
    chk(name, {66'h0, ok}, 67'd1);
  endtask

  initial begin
    logic [2:0] f3_tab [5];
    logic [2:0] f3;
    logic [31:0] rd;
    int s;
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010; f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;

    rst_in = 1'b1; rdy_in = 1'b1;
    bus.issue_valid = 0; bus.issue_is_store = 0; bus.issue_funct3 = 0; bus.issue_tag = 0;
    bus.issue_vj = 0; bus.issue_qj_busy = 0; bus.issue_qj = 0; bus.issue_vk = 0;
    bus.issue_qk_busy = 0; bus.issue_qk = 0; bus.issue_imm = 0;
    bus.cdb0_valid = 0; bus.cdb0_tag = 0; bus.cdb0_value = 0;
    bus.cdb1_valid = 0; bus.cdb1_tag = 0; bus.cdb1_value = 0;
    bus.commit_valid = 0; bus.commit_tag = 0; bus.roll_back = 0;
    repeat (3) @(negedge clk_in);

    // Reset values
    chk("rst_req_outs", req_word(bus.mem_req_we, bus.mem_req_size, bus.mem_req_addr, bus.mem_req_wdata)
        | {66'h0, bus.mem_req_valid}, 67'd0);
    chk("rst_bc_outs", {30'h0, bus.ld_bcast_valid, bus.ld_bcast_tag, bus.ld_bcast_value}, 67'd0);
    chk("rst_full", {66'h0, bus.full_out}, 67'd0);
    chk("rst_count", {62'h0, dbg_count}, 67'd0);
    rst_in = 1'b0;
    @(negedge clk_in);

    // Reset while a load is outstanding
    mem_hold = 1'b1;
    exp_req_q.push_back(req_word(1'b0, 2'd2, 32'h10, 32'h0));
    rd_q.push_back(32'hAAAA5555);
    issue_op(1'b0, 3'b010, 4'd1, 32'h10, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    for (int i = 0; i < 20 && !bus.mem_req_valid; i++) @(negedge clk_in);
    chk("midmem_req_seen", {66'h0, bus.mem_req_valid}, 67'd1);
    #1 rst_in = 1'b1;
    #1;
    chk("midmem_req_valid", {66'h0, bus.mem_req_valid}, 67'd0);
    chk("midmem_full", {66'h0, bus.full_out}, 67'd0);
    chk("midmem_fsm", {66'h0, dbg_fsm_state}, 67'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    mem_hold = 1'b0;
    repeat (8) @(negedge clk_in);
    chk("midmem_rd_used", rd_q.size(), 67'd0);

    // LW with ready operands
    expect_load(4'd3, 3'b010, 32'h104, 32'hDEADBEEF);
    issue_op(1'b0, 3'b010, 4'd3, 32'h100, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h4);
    wait_drain("lw_drain", 50);

    // LB woken by cdb0, LBU woken by cdb1
    expect_load(4'd1, 3'b000, 32'h208, 32'h80);
    issue_op(1'b0, 3'b000, 4'd1, 32'h0, 1'b1, 4'd5, 32'h0, 1'b0, 4'd0, 32'h8);
    cdb_pulse(0, 4'd5, 32'h200);
    wait_drain("lb_drain", 50);
    expect_load(4'd2, 3'b100, 32'h208, 32'h80);
    issue_op(1'b0, 3'b100, 4'd2, 32'h0, 1'b1, 4'd5, 32'h0, 1'b0, 4'd0, 32'h8);
    cdb_pulse(1, 4'd5, 32'h200);
    wait_drain("lbu_drain", 50);

    // LH capturing cdb1 in its issue cycle
    expect_load(4'd4, 3'b001, 32'h310, 32'h00008001);
    bus.cdb1_valid = 1'b1; bus.cdb1_tag = 4'd6; bus.cdb1_value = 32'h300;
    issue_op(1'b0, 3'b001, 4'd4, 32'h0, 1'b1, 4'd6, 32'h0, 1'b0, 4'd0, 32'h10);
    bus.cdb1_valid = 1'b0;
    wait_drain("lh_issue_capture", 50);

    // Both CDBs carry the awaited tag: cdb0 wins
    expect_load(4'd5, 3'b010, 32'h400, 32'h11223344);
    issue_op(1'b0, 3'b010, 4'd5, 32'h0, 1'b1, 4'd10, 32'h0, 1'b0, 4'd0, 32'h0);
    bus.cdb0_valid = 1'b1; bus.cdb0_tag = 4'd10; bus.cdb0_value = 32'h400;
    bus.cdb1_valid = 1'b1; bus.cdb1_tag = 4'd10; bus.cdb1_value = 32'h500;
    @(negedge clk_in);
    bus.cdb0_valid = 1'b0; bus.cdb1_valid = 1'b0;
    wait_drain("cdb_tie", 50);

    // Store blocks the load behind it until commit
    exp_req_q.push_back(req_word(1'b1, 2'd2, 32'h40, 32'h12345678));
    issue_op(1'b1, 3'b010, 4'd2, 32'h40, 1'b0, 4'd0, 32'h12345678, 1'b0, 4'd0, 32'h0);
    expect_load(4'd4, 3'b010, 32'h80, 32'hCAFEF00D);
    issue_op(1'b0, 3'b010, 4'd4, 32'h80, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    s = req_seen;
    repeat (8) @(negedge clk_in);
    chk("store_waits_commit", req_seen - s, 67'd0);
    commit_pulse(4'd2);
    wait_drain("store_then_load", 60);

    // Fill to full (head is mid-ring, so pointers wrap), drop a 17th, then drain
    for (int i = 0; i < DEPTH; i++) begin
      f3 = f3_tab[$urandom_range(0, 4)];
      rd = $urandom;
      expect_load(4'(i), f3, 32'h2000 + 32'(i * 16), rd);
      issue_op(1'b0, f3, 4'(i), 32'h0, 1'b1, 4'd7, 32'h0, 1'b0, 4'd0, 32'(i * 16));
    end
    chk("fill_full", {66'h0, bus.full_out}, 67'd1);
    chk("fill_count", {62'h0, dbg_count}, 67'd16);
    issue_op(1'b0, 3'b010, 4'd9, 32'h9000, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    chk("overflow_dropped", {62'h0, dbg_count}, 67'd16);
    mem_lat = $urandom_range(0, 2);
    cdb_pulse(0, 4'd7, 32'h2000);
    wait_drain("fill_drain", 400);
    chk("empty_full", {66'h0, bus.full_out}, 67'd0);
    mem_lat = 1;

    // Rollback: in-flight load, two committed stores, speculative loads
    mem_hold = 1'b1;
    exp_req_q.push_back(req_word(1'b0, 2'd2, 32'h1000, 32'h0));
    rd_q.push_back(32'h5A5A5A5A);
    issue_op(1'b0, 3'b010, 4'd1, 32'h1000, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    exp_req_q.push_back(req_word(1'b1, 2'd2, 32'h2000, 32'h11111111));
    issue_op(1'b1, 3'b010, 4'd2, 32'h2000, 1'b0, 4'd0, 32'h11111111, 1'b0, 4'd0, 32'h0);
    exp_req_q.push_back(req_word(1'b1, 2'd0, 32'h2004, 32'h00000022));
    issue_op(1'b1, 3'b000, 4'd3, 32'h2004, 1'b0, 4'd0, 32'h00000022, 1'b0, 4'd0, 32'h0);
    commit_pulse(4'd2);
    commit_pulse(4'd3);
    issue_op(1'b0, 3'b010, 4'd4, 32'h3000, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    issue_op(1'b0, 3'b010, 4'd5, 32'h0, 1'b1, 4'd9, 32'h0, 1'b0, 4'd0, 32'h0);
    chk("rb_pre_count", {62'h0, dbg_count}, 67'd5);
    chk("rb_pre_fsm", {66'h0, dbg_fsm_state}, 67'd1);
    bus.roll_back = 1'b1;
    issue_op(1'b0, 3'b010, 4'd6, 32'h4000, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    bus.roll_back = 1'b0;
    chk("rb_count", {62'h0, dbg_count}, 67'd2);
    chk("rb_fsm_holds", {66'h0, dbg_fsm_state}, 67'd1);
    mem_hold = 1'b0;
    wait_drain("rb_drain", 100);
    repeat (5) @(negedge clk_in);
    chk("rd_q_empty", rd_q.size(), 67'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsb_queue.md
Name: lsb_queue

Overview:
- Parametrised, in-order circular load/store buffer for the Tomasulo RISC-V core. It sits between issue/decoder, the two CDB broadcast channels, the ROB commit port and the memory controller.
- Holds LSB_DEPTH memory ops and wakes operands from both CDBs.
- Loads execute at the head once their operands are ready; stores execute at the head only after ROB commit.
- Load results are broadcast on its own CDB port. Rollback flushes speculative entries and preserves committed stores.

Parameters:
LSB_DEPTH, 16, number of entries; power of two, at least 4
PTR_W, 4, log2(LSB_DEPTH)
TAG_W, 4, ROB entry tag width
XLEN, 32, data/address width

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous active-high reset
rdy_in  input  1  global ready; low freezes all state and holds outputs
issue_valid  input  1  enqueue one op this cycle
issue_is_store  input  1  1=store, 0=load
issue_funct3  input  3  LB/LH/LW/LBU/LHU or SB/SH/SW
issue_tag  input  TAG_W  ROB tag of the op
issue_vj  input  XLEN  base value
issue_qj_busy  input  1  base operand not yet available
issue_qj  input  TAG_W  producer tag of the base
issue_vk  input  XLEN  store data
issue_qk_busy  input  1  store data not yet available
issue_qk  input  TAG_W  producer tag of the store data
issue_imm  input  XLEN  sign-extended offset
full_out  output  1  no free slot
cdb0_valid/cdb0_tag/cdb0_value  input  1/TAG_W/XLEN  RS ALU broadcast
cdb1_valid/cdb1_tag/cdb1_value  input  1/TAG_W/XLEN  LSB (own) broadcast, fed back
commit_valid  input  1  ROB commits a store
commit_tag  input  TAG_W  tag of the committed store
roll_back  input  1  misprediction flush
mem_req_valid  output  1  memory request
mem_req_we  output  1  1=write
mem_req_addr  output  XLEN  byte address
mem_req_wdata  output  XLEN  store data, low-aligned
mem_req_size  output  2  0=byte, 1=half, 2=word
mem_done  input  1  request complete, one-cycle pulse
mem_rdata  input  XLEN  raw load data, low-aligned
ld_bcast_valid  output  1  load result valid
ld_bcast_tag  output  TAG_W  ROB tag of the load
ld_bcast_value  output  XLEN  extended load result

Behaviour:
- Reset (async): head=tail=0, count=0, all entries EMPTY, FSM=IDLE. Every output is 0 except full_out, which is 0.
- rdy_in=0: no register updates. Inputs arriving that cycle, including issue, CDB, commit and roll_back, are lost; upstream must hold them.
- Entry states:
  - EMPTY.
  - WAIT: one or more operands busy.
  - READY: operands present.
  - COMMITTED: store only.
- Issue:
  - Writes slot[tail]; tail=tail+1 mod LSB_DEPTH; count+1.
  - Issue while full_out=1 is ignored.
  - A busy operand whose tag matches a valid CDB in the same cycle captures that value and is marked not-busy.
- Wakeup: every cycle, every WAIT entry compares its Qj/Qk against both CDBs. On a match it latches the value. If both CDBs match the same tag, cdb0 wins.
- commit_valid: the store entry with matching tag is marked COMMITTED. It must already be READY, which the ROB guarantees.
- Head FSM:
  - IDLE -> MEM: the head entry is either a READY load, or a COMMITTED store.
  - On that transition, assert mem_req_valid for one cycle with:
    - addr=vj+imm, wrap mod 2^XLEN;
    - size from funct3[1:0];
    - wdata=vk.
  - MEM waits for mem_done.
  - On mem_done:
    - Free the head, head+1, count-1.
    - For a load, pulse ld_bcast for one cycle with the value sign- or zero-extended per funct3 (LB/LH sign-extend; LBU/LHU zero-extend).
    - Return to IDLE.
  - mem_done when IDLE is ignored.
  - Minimum load latency from the head becoming READY: 1 cycle to request, then memory latency, then broadcast in the cycle after mem_done.
- Simultaneous issue and dequeue in one cycle: count is unchanged. full_out is driven from the registered count: full_out=(count==LSB_DEPTH).
- roll_back:
  - Every non-COMMITTED entry becomes EMPTY.
  - tail = head + number of COMMITTED entries. Committed stores are contiguous from head.
  - A load in MEM completes its memory access, but its ld_bcast is suppressed.
  - A store in MEM continues normally.
  - issue_valid and commit_valid in the same cycle as roll_back are ignored.
- Wrap-around: pointers are PTR_W bits and wrap naturally. Full vs empty is distinguished by count.

Test Plan:
- Reset mid-MEM (assert rst_in with a load outstanding) -> mem_req_valid=0, full_out=0 immediately; a later mem_done produces no broadcast.
- Issue LW tag 3 with vj=0x100, imm=4, operands ready; mem_done with rdata=0xDEADBEEF -> request addr=0x104, size=2; then ld_bcast tag 3, value 0xDEADBEEF.
- Issue LB with qj_busy, qj=5; cdb0 tag 5 value 0x200; rdata=0x80 -> addr=0x200+imm; broadcast value 0xFFFFFF80. Repeat with LBU -> 0x00000080.
- Issue SW tag 2 (ready), then LW tag 4 -> no request until commit_tag=2. Then write request with wdata=vk, then the load request.
- Fill 16 entries -> full_out=1; a 17th issue is dropped. Drain all, with the pointers wrapping past 15 -> 0 -> order preserved.
- Two committed stores plus three speculative loads, one of them in MEM, then roll_back -> count=2; the in-flight load gives no broadcast; both stores are written in order.
